// File: rtl/ahb_pkg.sv
// AHB encodings and the master FSM state type shared by the bridge and its bench.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_ADDR = 2'b10,
        ST_DATA = 2'b11
    } state_e;

endpackage

// File: rtl/ahb_master_interface_if.sv
// Command side (from the master module) and AHB side of the single-transfer master bridge.
interface ahb_master_interface_if;

    logic        enable;
    logic        hbusreq_in;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic [1:0]  slv_sel_in;
    logic        hgrant;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    logic        hbusreq;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [1:0]  hsel_out;
    logic [31:0] dout;
    logic        busy;
    logic        xfer_done;
    logic        xfer_err;

    modport master (
        input  enable, hbusreq_in, wr, addr, din, slv_sel_in,
        input  hgrant, hready, hresp, hrdata,
        output hbusreq, haddr, htrans, hwrite, hsize, hburst, hwdata,
        output hsel_out, dout, busy, xfer_done, xfer_err
    );

    modport slave (
        output enable, hbusreq_in, wr, addr, din, slv_sel_in,
        output hgrant, hready, hresp, hrdata,
        input  hbusreq, haddr, htrans, hwrite, hsize, hburst, hwdata,
        input  hsel_out, dout, busy, xfer_done, xfer_err
    );

endinterface

// File: rtl/ahb_master_interface.sv
// Single-transfer AHB master: latches one command in IDLE, requests the bus, runs one
// NONSEQ word transfer, retries on RETRY/SPLIT and reports done/error as one-cycle pulses.
module ahb_master_interface
    import ahb_pkg::*;
(
    input  logic                  hclk,
    input  logic                  hreset,
    ahb_master_interface_if.master bus
);

    state_e      state, state_nxt;
    logic        accept, data_ok, data_err;

    logic [31:0] cmd_addr, cmd_din;
    logic        cmd_wr;
    logic [1:0]  cmd_sel;
    logic [31:0] haddr_q, hwdata_q, dout_q;
    logic        hwrite_q;
    logic [2:0]  hsize_q;
    logic        done_q, err_q;

    always_ff @(posedge hclk) begin
        if (hreset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        data_ok   = 1'b0;
        data_err  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.enable && bus.hbusreq_in) begin
                    accept    = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ:  if (bus.hgrant && bus.hready) state_nxt = ST_ADDR;
            ST_ADDR: if (bus.hready) state_nxt = ST_DATA;
            ST_DATA: begin
                // hready low covers both wait states and the first cycle of a two-cycle response
                if (bus.hready) begin
                    case (bus.hresp)
                        HRESP_OKAY: begin
                            data_ok   = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                        HRESP_ERROR: begin
                            data_err  = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                        default: state_nxt = ST_REQ;
                    endcase
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            cmd_addr <= '0;
            cmd_din  <= '0;
            cmd_wr   <= 1'b0;
            cmd_sel  <= '0;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            hwdata_q <= '0;
            dout_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= data_ok;
            err_q  <= data_err;
            if (accept) begin
                cmd_addr <= bus.addr;
                cmd_din  <= bus.din;
                cmd_wr   <= bus.wr;
                cmd_sel  <= bus.slv_sel_in;
            end
            // address-phase fields are loaded on entry so they are stable for the whole ADDR cycle
            if (state == ST_REQ && state_nxt == ST_ADDR) begin
                haddr_q  <= cmd_addr;
                hwrite_q <= cmd_wr;
                hsize_q  <= HSIZE_WORD;
            end
            if (state == ST_ADDR && state_nxt == ST_DATA && cmd_wr) hwdata_q <= cmd_din;
            if (data_ok && !cmd_wr) dout_q <= bus.hrdata;
        end
    end

    assign bus.hbusreq   = (state == ST_REQ) || (state == ST_ADDR);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.htrans    = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.haddr     = haddr_q;
    assign bus.hwrite    = hwrite_q;
    assign bus.hsize     = hsize_q;
    assign bus.hburst    = HBURST_SINGLE;
    assign bus.hwdata    = hwdata_q;
    assign bus.hsel_out  = cmd_sel;
    assign bus.dout      = dout_q;
    assign bus.xfer_done = done_q;
    assign bus.xfer_err  = err_q;

endmodule

// File: tb/tb_ahb_master_interface.sv
// Directed and randomized transfers against a transaction-level model of the bridge.
module tb_ahb_master_interface;
    import ahb_pkg::*;

    logic hclk;
    logic hreset;
    int   checks;
    int   errors;

    logic [31:0] m_dout;
    logic [31:0] m_hwdata;

    ahb_master_interface_if bus();

    ahb_master_interface dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus.master)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic en, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] sel);
        bus.enable     = en;
        bus.hbusreq_in = en;
        bus.wr         = w;
        bus.addr       = a;
        bus.din        = d;
        bus.slv_sel_in = sel;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hbusreq"}, 32'(bus.hbusreq), 32'd0);
        chk({tag, "_htrans"},  32'(bus.htrans), 32'(HTRANS_IDLE));
        chk({tag, "_haddr"},   bus.haddr, 32'd0);
        chk({tag, "_hwrite"},  32'(bus.hwrite), 32'd0);
        chk({tag, "_hsize"},   32'(bus.hsize), 32'd0);
        chk({tag, "_hburst"},  32'(bus.hburst), 32'd0);
        chk({tag, "_hwdata"},  bus.hwdata, 32'd0);
        chk({tag, "_hsel"},    32'(bus.hsel_out), 32'd0);
        chk({tag, "_dout"},    bus.dout, 32'd0);
        chk({tag, "_busy"},    32'(bus.busy), 32'd0);
        chk({tag, "_done"},    32'(bus.xfer_done), 32'd0);
        chk({tag, "_err"},     32'(bus.xfer_err), 32'd0);
    endtask

    // One command: gdly REQ cycles without grant, stall DATA wait cycles, then the given
    // response (RETRY/SPLIT re-run the transfer once, finishing with OKAY).
    task automatic xfer(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input logic [1:0] sel, input int gdly,
                        input int stall, input logic [1:0] resp);
        logic [1:0] r;
        logic [31:0] exp_wd;
        bit finished;
        r = resp;
        finished = 1'b0;
        exp_wd = w ? d : m_hwdata;
        set_cmd(1'b1, w, a, d, sel);
        bus.hgrant = 1'b0;
        bus.hready = 1'b1;
        bus.hresp  = HRESP_OKAY;
        step();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        chk({tag, "_acc_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_acc_hsel"}, 32'(bus.hsel_out), 32'(sel));
        while (!finished) begin
            for (int i = 0; i < gdly; i++) begin
                bus.hgrant = 1'b0;
                chk({tag, "_req_hbusreq"}, 32'(bus.hbusreq), 32'd1);
                chk({tag, "_req_htrans"},  32'(bus.htrans), 32'(HTRANS_IDLE));
                step();
            end
            bus.hgrant = 1'b1;
            chk({tag, "_grant_hbusreq"}, 32'(bus.hbusreq), 32'd1);
            step();
            bus.hgrant = 1'b0;
            chk({tag, "_addr_htrans"},  32'(bus.htrans), 32'(HTRANS_NONSEQ));
            chk({tag, "_addr_haddr"},   bus.haddr, a);
            chk({tag, "_addr_hwrite"},  32'(bus.hwrite), 32'(w));
            chk({tag, "_addr_hsize"},   32'(bus.hsize), 32'(HSIZE_WORD));
            chk({tag, "_addr_hburst"},  32'(bus.hburst), 32'(HBURST_SINGLE));
            step();
            for (int i = 0; i < stall; i++) begin
                bus.hready = 1'b0;
                bus.hresp  = (i == stall - 1) ? r : HRESP_OKAY;
                chk({tag, "_data_htrans"},  32'(bus.htrans), 32'(HTRANS_IDLE));
                chk({tag, "_data_hbusreq"}, 32'(bus.hbusreq), 32'd0);
                chk({tag, "_data_hwdata"},  bus.hwdata, exp_wd);
                chk({tag, "_data_pulse"},   32'({bus.xfer_done, bus.xfer_err}), 32'd0);
                step();
            end
            bus.hready = 1'b1;
            bus.hresp  = r;
            bus.hrdata = rd;
            chk({tag, "_last_hwdata"}, bus.hwdata, exp_wd);
            chk({tag, "_last_busy"},   32'(bus.busy), 32'd1);
            step();
            bus.hresp = HRESP_OKAY;
            case (r)
                HRESP_OKAY: begin
                    if (!w) m_dout = rd;
                    chk({tag, "_done"}, 32'(bus.xfer_done), 32'd1);
                    chk({tag, "_err"},  32'(bus.xfer_err), 32'd0);
                    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
                    finished = 1'b1;
                end
                HRESP_ERROR: begin
                    chk({tag, "_done"}, 32'(bus.xfer_done), 32'd0);
                    chk({tag, "_err"},  32'(bus.xfer_err), 32'd1);
                    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
                    finished = 1'b1;
                end
                default: begin
                    chk({tag, "_retry_pulse"},   32'({bus.xfer_done, bus.xfer_err}), 32'd0);
                    chk({tag, "_retry_hbusreq"}, 32'(bus.hbusreq), 32'd1);
                    chk({tag, "_retry_htrans"},  32'(bus.htrans), 32'(HTRANS_IDLE));
                    r = HRESP_OKAY;
                end
            endcase
        end
        chk({tag, "_dout"}, bus.dout, m_dout);
        if (w) m_hwdata = d;
        step();
        chk({tag, "_pulse_once"}, 32'({bus.xfer_done, bus.xfer_err}), 32'd0);
        chk({tag, "_idle_busy"},  32'(bus.busy), 32'd0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        m_dout   = 32'h0;
        m_hwdata = 32'h0;
        hreset   = 1'b1;
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        bus.hgrant = 1'b0;
        bus.hready = 1'b1;
        bus.hresp  = HRESP_OKAY;
        bus.hrdata = 32'h0;
        step();
        step();
        chk_reset_outputs("rst");
        hreset = 1'b0;

        // enable without a bus request is ignored
        bus.enable = 1'b1;
        step();
        chk("ign_busy", 32'(bus.busy), 32'd0);
        bus.enable = 1'b0;

        // best case with command held: write 0x0/din=1, then an automatic repeat
        set_cmd(1'b1, 1'b1, 32'h0, 32'h1, 2'b01);
        bus.hgrant = 1'b1;
        step();
        chk("bc_c1_hbusreq", 32'(bus.hbusreq), 32'd1);
        chk("bc_c1_htrans",  32'(bus.htrans), 32'(HTRANS_IDLE));
        step();
        chk("bc_c2_htrans",  32'(bus.htrans), 32'(HTRANS_NONSEQ));
        chk("bc_c2_haddr",   bus.haddr, 32'h0);
        step();
        chk("bc_c3_hwdata",  bus.hwdata, 32'h1);
        chk("bc_c3_done",    32'(bus.xfer_done), 32'd0);
        step();
        chk("bc_c4_done",    32'(bus.xfer_done), 32'd1);
        chk("bc_c4_busy",    32'(bus.busy), 32'd0);
        step();
        chk("bc_rep_busy",   32'(bus.busy), 32'd1);
        chk("bc_rep_done",   32'(bus.xfer_done), 32'd0);
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        step();
        step();
        step();
        chk("bc_rep_done2",  32'(bus.xfer_done), 32'd1);
        m_hwdata = 32'h1;
        step();
        chk("bc_rep_idle",   32'(bus.busy), 32'd0);

        xfer("rd_stall",  1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 2'd2, 0, 2, HRESP_OKAY);
        xfer("gnt_wait",  1'b1, 32'h0000_2004, 32'hA5A5_0001, 32'h0, 2'd3, 5, 0, HRESP_OKAY);
        xfer("err",       1'b0, 32'h0000_3008, 32'h0, 32'h1234_5678, 2'd1, 0, 1, HRESP_ERROR);
        xfer("retry",     1'b1, 32'h0000_400C, 32'hCAFE_F00D, 32'h0, 2'd0, 1, 1, HRESP_RETRY);
        xfer("split",     1'b0, 32'h0000_5010, 32'h0, 32'h0BAD_CAFE, 2'd2, 2, 1, HRESP_SPLIT);

        for (int n = 0; n < 24; n++) begin
            logic [1:0] rsp;
            int st;
            rsp = 2'($urandom_range(0, 3));
            st  = $urandom_range(0, 2);
            if (rsp != HRESP_OKAY && st == 0) st = 1;
            xfer($sformatf("rnd%0d", n), 1'($urandom), $urandom, $urandom, $urandom,
                 2'($urandom), $urandom_range(0, 3), st, rsp);
        end

        // reset in DATA abandons the read with no pulse
        set_cmd(1'b1, 1'b0, 32'h0000_7777, 32'h0, 2'd3);
        bus.hgrant = 1'b1;
        bus.hready = 1'b1;
        step();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        step();
        step();
        bus.hrdata = 32'h5555_AAAA;
        bus.hresp  = HRESP_OKAY;
        hreset     = 1'b1;
        step();
        chk_reset_outputs("rstdata");
        m_dout   = 32'h0;
        m_hwdata = 32'h0;
        hreset   = 1'b0;
        set_cmd(1'b1, 1'b0, 32'h0000_8888, 32'h0, 2'd1);
        step();
        chk("post_rst_busy", 32'(bus.busy), 32'd1);
        chk("post_rst_hsel", 32'(bus.hsel_out), 32'd1);
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
        step();
        chk("post_rst_haddr", bus.haddr, 32'h0000_8888);
        step();
        bus.hrdata = 32'h0F0F_0F0F;
        step();
        chk("post_rst_done", 32'(bus.xfer_done), 32'd1);
        chk("post_rst_dout", bus.dout, 32'h0F0F_0F0F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
